// File: rtl/router_switch_allocator.sv
// Wormhole switch allocator: one IDLE/ACTIVE lock per output, round-robin arbitration on HEAD flits.
// Define ROUTER_SA_WATCHDOG_EN to add a per-output stall watchdog that force-releases a stuck lock.
module router_switch_allocator #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned PORT_BITS   = $clog2(NUM_PORTS),
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [2*NUM_PORTS-1:0]         in_flit_type,
  input  logic [PORT_BITS*NUM_PORTS-1:0] in_dest,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           in_grant,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [PORT_BITS*NUM_PORTS-1:0] xbar_sel,
  output logic [NUM_PORTS-1:0]           out_busy,
  output logic [NUM_PORTS-1:0]           wdog_err
);

  typedef enum logic [1:0] {
    FT_HEAD = 2'd0,
    FT_TAIL = 2'd1,
    FT_BODY = 2'd2,
    FT_NONE = 2'd3
  } flit_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd2
  } state_t;

  state_t               state_q [NUM_PORTS];
  state_t               state_d [NUM_PORTS];
  logic [PORT_BITS-1:0] owner_q [NUM_PORTS];
  logic [PORT_BITS-1:0] owner_d [NUM_PORTS];
  logic [PORT_BITS-1:0] rr_q    [NUM_PORTS];
  logic [PORT_BITS-1:0] rr_d    [NUM_PORTS];

  flit_type_t           ftype   [NUM_PORTS];
  logic [PORT_BITS-1:0] dest    [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] is_tail;
  logic [NUM_PORTS-1:0] timeout;

  function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
    return PORT_BITS'((32'(p) + 1) % NUM_PORTS);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      ftype[i] = flit_type_t'(in_flit_type[2*i +: 2]);
      dest[i]  = in_dest[PORT_BITS*i +: PORT_BITS];
    end
  end

  always_comb begin
    xfer    = '0;
    is_tail = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      xfer[o]    = (state_q[o] == ACTIVE) && in_valid[owner_q[o]] && out_ready[o] &&
                   (ftype[owner_q[o]] != FT_NONE);
      is_tail[o] = (ftype[owner_q[o]] == FT_TAIL);
    end
  end

`ifdef ROUTER_SA_WATCHDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES);

  logic [7:0] stall_q [NUM_PORTS];
  logic [7:0] stall_d [NUM_PORTS];

  // Counter idles at zero outside ACTIVE, so a fresh lock always starts from a clean count.
  always_comb begin
    timeout = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      timeout[o] = (state_q[o] == ACTIVE) && !xfer[o] && (stall_q[o] == WDOG_LIM);
      stall_d[o] = stall_q[o];
      if ((state_q[o] != ACTIVE) || xfer[o] || timeout[o]) begin
        stall_d[o] = '0;
      end else begin
        stall_d[o] = stall_q[o] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) stall_q[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) stall_q[o] <= stall_d[o];
    end
  end
`else
  logic [7:0] unused_wdog_cycles;
  assign unused_wdog_cycles = 8'(WDOG_CYCLES);

  always_comb begin
    timeout = '0;
  end
`endif

  assign wdog_err = timeout;

  always_comb begin : p_next
    logic                 found;
    logic [PORT_BITS-1:0] cand;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      found      = 1'b0;
      cand       = '0;
      case (state_q[o])
        IDLE: begin
          // Scan from the round-robin pointer upward; first HEAD aimed at this output wins.
          for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = PORT_BITS'((32'(rr_q[o]) + k) % NUM_PORTS);
            if (!found && in_valid[cand] && (ftype[cand] == FT_HEAD) &&
                (dest[cand] == PORT_BITS'(o))) begin
              found      = 1'b1;
              owner_d[o] = cand;
              state_d[o] = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (timeout[o] || (xfer[o] && is_tail[o])) begin
            state_d[o] = IDLE;
            rr_d[o]    = next_port(owner_q[o]);
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  assign out_valid = xfer;

  always_comb begin
    in_grant = '0;
    out_busy = '0;
    xbar_sel = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (xfer[o]) in_grant[owner_q[o]] = 1'b1;
      out_busy[o]                        = (state_q[o] == ACTIVE);
      xbar_sel[PORT_BITS*o +: PORT_BITS] = owner_q[o];
    end
  end

endmodule

// File: tb/tb_router_switch_allocator.sv
// Directed bench for router_switch_allocator: per-input flit sources, a packet-level
// allocator model compared every cycle, plus literal expectations at key cycles.
module tb_router_switch_allocator;
  localparam int N  = 4;
  localparam int PB = 2;
  localparam int WD = 4;
  localparam logic [1:0] H  = 2'd0;
  localparam logic [1:0] T  = 2'd1;
  localparam logic [1:0] B  = 2'd2;
  localparam logic [1:0] NF = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid, out_ready, in_grant, out_valid, out_busy, wdog_err;
  logic [2*N-1:0]  in_flit_type;
  logic [PB*N-1:0] in_dest, xbar_sel;

  int checks = 0;
  int errors = 0;

  router_switch_allocator #(.NUM_PORTS(N), .PORT_BITS(PB), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit_type(in_flit_type),
    .in_dest(in_dest), .out_ready(out_ready), .in_grant(in_grant), .out_valid(out_valid),
    .xbar_sel(xbar_sel), .out_busy(out_busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  // Input buffer heads: each entry is {type, dest}
  logic [3:0] fbuf [N][64];
  int         rd [N];
  int         wr [N];
  int         gcount [N];
  logic [N-1:0] en_n, rdy_n, grant_seen;
  logic         rst_nxt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [1:0] t, input int d);
    fbuf[i][wr[i]] = {t, 2'(d)};
    wr[i]++;
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    grant_seen = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [3:0] f;
      f = (rd[i] != wr[i]) ? fbuf[i][rd[i]] : {NF, 2'b00};
      in_valid[i]          = en_n[i] && (rd[i] != wr[i]);
      in_flit_type[2*i +: 2] = f[3:2];
      in_dest[PB*i +: PB]    = f[1:0];
    end
    out_ready = rdy_n;
    rst_n     = rst_nxt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (grant_seen[i] && rd[i] < wr[i]) rd[i]++;
    drive();
  endtask

  // Packet-level model: owner (-1 = free), last owner, round-robin pointer, stall count.
  int m_own [N];
  int m_sel [N];
  int m_rr  [N];
  int m_cnt [N];

  always @(negedge clk) begin
    logic [N-1:0]    eg, ev, eb, ew;
    logic [PB*N-1:0] es;
    eg = '0; ev = '0; eb = '0; ew = '0; es = '0;
    if (!rst_n) begin
      for (int o = 0; o < N; o++) begin
        m_own[o] = -1; m_sel[o] = 0; m_rr[o] = 0; m_cnt[o] = 0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        es[PB*o +: PB] = PB'(m_sel[o]);
        eb[o] = (m_own[o] >= 0);
        if (m_own[o] >= 0) begin
          int k;
          logic [1:0] t;
          k = m_own[o];
          t = in_flit_type[2*k +: 2];
          if (in_valid[k] && out_ready[o] && t != NF) begin
            eg[k] = 1'b1;
            ev[o] = 1'b1;
            m_cnt[o] = 0;
            if (t == T) begin
              m_own[o] = -1;
              m_rr[o]  = (k + 1) % N;
            end
          end else begin
`ifdef ROUTER_SA_WATCHDOG_EN
            if (m_cnt[o] == WD) begin
              ew[o] = 1'b1;
              m_own[o] = -1;
              m_rr[o]  = (k + 1) % N;
              m_cnt[o] = 0;
            end else begin
              m_cnt[o]++;
            end
`endif
          end
        end else begin
          for (int s = 0; s < N; s++) begin
            int c;
            c = (m_rr[o] + s) % N;
            if (m_own[o] < 0 && in_valid[c] && in_flit_type[2*c +: 2] == H &&
                int'(in_dest[PB*c +: PB]) == o) begin
              m_own[o] = c;
              m_sel[o] = c;
              m_cnt[o] = 0;
            end
          end
        end
      end
    end
    chk("cyc in_grant", in_grant, eg);
    chk("cyc out_valid", out_valid, ev);
    chk("cyc out_busy", out_busy, eb);
    chk("cyc xbar_sel", xbar_sel, es);
    chk("cyc wdog_err", wdog_err, ew);
    grant_seen = rst_n ? in_grant : '0;
    for (int i = 0; i < N; i++) if (in_grant[i]) gcount[i]++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    rst_nxt = 1'b0; en_n = '1; rdy_n = '1;
    flush_all();
    drive();
    step(); #2;
    chk("reset in_grant", in_grant, 0);
    chk("reset out_busy", out_busy, 0);
    chk("reset xbar_sel", xbar_sel, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset wdog_err", wdog_err, 0);
    step();
    rst_nxt = 1'b1;
    step();

    // Single packet, input 1 -> output 2
    flush_all();
    push(1, H, 2); push(1, B, 3); push(1, B, 0); push(1, T, 1);
    step(); #2;
    chk("t1 c0 grant", in_grant, 4'b0000);
    chk("t1 c0 busy", out_busy, 4'b0000);
    step(); #2;
    chk("t1 c1 busy2", out_busy[2], 1'b1);
    chk("t1 c1 sel2", xbar_sel[5:4], 2'd1);
    chk("t1 c1 grant", in_grant, 4'b0010);
    step(); step(); step(); #2;
    chk("t1 c4 grant", in_grant, 4'b0010);
    chk("t1 c4 ovalid", out_valid, 4'b0100);
    step(); #2;
    chk("t1 c5 busy", out_busy, 4'b0000);
    step();

    // Contention on output 1: inputs 0 and 3, round-robin
    flush_all();
    push(0, H, 1); push(0, B, 0); push(0, T, 0); push(0, H, 1); push(0, T, 2);
    push(3, H, 1); push(3, B, 1); push(3, T, 1);
    step(); step(); #2;
    chk("t2 c1 grant", in_grant, 4'b0001);
    chk("t2 c1 sel1", xbar_sel[3:2], 2'd0);
    step(); step(); step(); #2;
    chk("t2 c4 busy1", out_busy[1], 1'b0);
    chk("t2 c4 grant", in_grant, 4'b0000);
    step(); #2;
    chk("t2 c5 grant", in_grant, 4'b1000);
    chk("t2 c5 sel1", xbar_sel[3:2], 2'd3);
    step(); step(); step(); step(); #2;
    chk("t2 c9 grant", in_grant, 4'b0001);
    step(); step(); step();

    // Backpressure on output 0 owned by input 2
    flush_all();
    push(2, H, 0); push(2, B, 1); push(2, B, 2); push(2, B, 3); push(2, T, 0);
    g0 = gcount[2];
    for (int c = 0; c < 10; c++) begin
      rdy_n = (c >= 3 && c <= 5) ? 4'b1110 : 4'b1111;
      step(); #2;
      if (c == 3) begin
        chk("t3 c3 grant", in_grant, 4'b0000);
        chk("t3 c3 ovalid", out_valid, 4'b0000);
      end
      if (c == 6) chk("t3 c6 grant", in_grant, 4'b0100);
    end
    step();
    chk("t3 grants", 16'(gcount[2] - g0), 16'd5);
    chk("t3 drained", 16'(wr[2] - rd[2]), 16'd0);

    // Parallel locks: 0->3 and 1->2
    flush_all();
    push(0, H, 3); push(0, B, 0); push(0, B, 0); push(0, T, 0);
    push(1, H, 2); push(1, B, 0); push(1, B, 0); push(1, T, 0);
    step(); step(); step(); #2;
    chk("t4 c2 grant", in_grant, 4'b0011);
    chk("t4 c2 busy", out_busy, 4'b1100);
    chk("t4 c2 ovalid", out_valid, 4'b1100);
    chk("t4 c2 sel", xbar_sel, 8'h12);
    step(); step(); step(); step();

    // Reset mid-packet on output 1
    flush_all();
    push(3, H, 1); push(3, B, 0); push(3, B, 0); push(3, T, 0);
    step(); step(); step(); #2;
    chk("t5 c2 grant", in_grant, 4'b1000);
    rst_nxt = 1'b0; rst_n = 1'b0;
    #1;
    chk("t5 rst grant", in_grant, 4'b0000);
    chk("t5 rst busy", out_busy, 4'b0000);
    chk("t5 rst ovalid", out_valid, 4'b0000);
    chk("t5 rst sel", xbar_sel, 8'h00);
    step();
    rst_nxt = 1'b1;
    step();
    flush_all();
    push(3, H, 1); push(3, T, 0);
    step(); #2;
    chk("t5 r0 grant", in_grant, 4'b0000);
    step(); #2;
    chk("t5 r1 grant", in_grant, 4'b1000);
    chk("t5 r1 sel1", xbar_sel[3:2], 2'd3);
    step(); step();

    // Stray BODY/TAIL/NONE never granted, then owner HEAD as data on loopback
    flush_all();
    push(0, B, 1); push(1, T, 2); push(2, NF, 3);
    step(); step(); step(); #2;
    chk("t6 stray grant", in_grant, 4'b0000);
    chk("t6 stray busy", out_busy, 4'b0000);
    flush_all();
    push(0, H, 0); push(0, H, 0); push(0, T, 0);
    step(); step(); step(); #2;
    chk("t6 c2 grant", in_grant, 4'b0001);
    chk("t6 c2 busy", out_busy, 4'b0001);
    step(); step(); #2;
    chk("t6 c4 busy", out_busy, 4'b0000);
    step();

    // Owner stalls with in_valid low
    flush_all();
    push(1, H, 3); push(1, B, 0); push(1, T, 0);
    step(); step();
    en_n = 4'b1101;
    for (int c = 2; c < 10; c++) begin
      step(); #2;
`ifdef ROUTER_SA_WATCHDOG_EN
      if (c == 6) chk("t7 wdog pulse", wdog_err, 4'b1000);
      if (c == 7) chk("t7 busy drop", out_busy[3], 1'b0);
`else
      if (c == 9) begin
        chk("t7 lock held", out_busy[3], 1'b1);
        chk("t7 no wdog", wdog_err, 4'b0000);
      end
`endif
    end
    en_n = '1;
`ifdef ROUTER_SA_WATCHDOG_EN
    flush_all();
    step(); step();
`else
    step(); step(); step(); #2;
    chk("t7 drained busy", out_busy, 4'b0000);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
